// File: rtl/sync_down_counter.sv
// Presettable synchronous down counter built as a T-flip-flop chain, clocked on the falling edge.
// Optional auto-reload of the underflow value is enabled by defining DOWN_CNT_RELOAD_EN.
module sync_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             ZERO,
  output logic             TC
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] toggle;
  logic             underflow;

  // A bit toggles when every lower bit is zero, so the toggle enables form a borrow chain.
  always_comb begin
    toggle    = '0;
    toggle[0] = EN;
    for (int i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & ~Q[i-1];
    end
  end

  assign ZERO      = (Q == '0);
  assign underflow = EN & ~LOAD & ZERO;

`ifdef DOWN_CNT_RELOAD_EN
  logic [WIDTH-1:0] rld;

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      Q   <= '0;
      TC  <= 1'b0;
      rld <= ALL_ONES;
    end else begin
      TC <= underflow;
      if (LOAD) begin
        Q   <= D;
        rld <= D;
      end else if (underflow) begin
        Q <= rld;
      end else begin
        Q <= Q ^ toggle;
      end
    end
  end
`else
  // Toggling every bit from zero lands on all-ones, which is exactly the plain modulo wrap.
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      Q  <= '0;
      TC <= 1'b0;
    end else begin
      TC <= underflow;
      if (LOAD) begin
        Q <= D;
      end else begin
        Q <= Q ^ toggle;
      end
    end
  end
`endif

endmodule
